// File: rtl/instruction_fetch_data_pkg.sv
// Shared I-cache geometry, tag/data stage interface structs and fill FSM encoding.
// Used by instruction_fetch_data (optional perf counters: ICACHE_PERF_CNT_EN).
package instruction_fetch_data_pkg;

  localparam int ICACHE_NUM_WAYS     = 2;
  localparam int ICACHE_NUM_SETS     = 16;
  localparam int ICACHE_NUM_SET_BITS = $clog2(ICACHE_NUM_SETS);
  localparam int ICACHE_LINE_WORDS   = 8;
  localparam int ICACHE_OFF_BITS     = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_NUM_TAG_BITS = 32 - ICACHE_NUM_SET_BITS - ICACHE_OFF_BITS - 2;
  localparam int ICACHE_WAY_BITS     = (ICACHE_NUM_WAYS > 1) ? $clog2(ICACHE_NUM_WAYS) : 1;

  typedef struct packed {
    logic [ICACHE_NUM_TAG_BITS-1:0] tag;
    logic [ICACHE_NUM_SET_BITS-1:0] set_idx;
    logic [ICACHE_OFF_BITS-1:0]     offset;
    logic [1:0]                     byte_off;
  } ifu_address_t;

  typedef struct packed {
    ifu_address_t                                        fetched_pc;
    logic [ICACHE_NUM_WAYS-1:0]                          valid_bits;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_NUM_TAG_BITS-1:0] tags_read;
  } ift_ifd_inf_t;

  typedef struct packed {
    logic                           cache_miss;
    logic                           resume_fetch;
    logic                           cache_fetch_fsm_idle;
    logic [ICACHE_NUM_WAYS-1:0]     update_tag_en;
    logic [ICACHE_NUM_SET_BITS-1:0] update_tag_set;
    logic [ICACHE_NUM_TAG_BITS-1:0] update_tag;
  } ifd_ift_inf_t;

  typedef enum logic [2:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_FILL,
    FILL_UPDATE,
    FILL_RESUME
  } fill_state_e;

endpackage

// File: rtl/bram_1r1w.sv
// Simple one-write / one-read data array; read is asynchronous so the fetch
// stage can register the selected word directly into the IX output.
module bram_1r1w #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch_data_icache_line_fill.sv
// Single-outstanding I-cache line fill: memory request, beat write into the
// round-robin victim way, tag write-back to the tag stage, then fetch resume.
module instruction_fetch_data_icache_line_fill
  import instruction_fetch_data_pkg::*;
#(
  parameter int LINE_WORDS     = ICACHE_LINE_WORDS,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     miss,
  input  logic [ICACHE_NUM_TAG_BITS-1:0]           miss_tag,
  input  logic [ICACHE_NUM_SET_BITS-1:0]           miss_set,
  output logic                                     mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0]                mem_rd_addr,
  input  logic                                     mem_rd_gnt,
  input  logic                                     mem_rd_data_valid,
  input  logic [31:0]                              mem_rd_data,
  output logic [ICACHE_NUM_WAYS-1:0]               wr_en,
  output logic [ICACHE_NUM_SET_BITS+ICACHE_OFF_BITS-1:0] wr_addr,
  output logic [31:0]                              wr_data,
  output logic [ICACHE_NUM_WAYS-1:0]               update_tag_en,
  output logic [ICACHE_NUM_SET_BITS-1:0]           update_tag_set,
  output logic [ICACHE_NUM_TAG_BITS-1:0]           update_tag,
  output logic                                     resume_fetch,
  output logic                                     fsm_idle
);

  fill_state_e                                      state, state_nxt;
  logic [ICACHE_NUM_TAG_BITS-1:0]                   line_tag;
  logic [ICACHE_NUM_SET_BITS-1:0]                   line_set;
  logic [ICACHE_OFF_BITS-1:0]                       beat_cnt;
  logic [ICACHE_NUM_SETS-1:0][ICACHE_WAY_BITS-1:0]  rr_ptr;
  logic [ICACHE_WAY_BITS-1:0]                       victim;
  logic                                             last_beat;

  assign victim    = rr_ptr[line_set];
  assign last_beat = mem_rd_data_valid && (beat_cnt == ICACHE_OFF_BITS'(LINE_WORDS-1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt     = state;
    mem_rd_req    = 1'b0;
    wr_en         = '0;
    update_tag_en = '0;
    resume_fetch  = 1'b0;
    fsm_idle      = 1'b0;
    case (state)
      FILL_IDLE: begin
        fsm_idle = 1'b1;
        if (miss) state_nxt = FILL_REQ;
      end
      FILL_REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_gnt) state_nxt = FILL_FILL;
      end
      FILL_FILL: if (mem_rd_data_valid) begin
        wr_en[victim] = 1'b1;
        if (last_beat) state_nxt = FILL_UPDATE;
      end
      FILL_UPDATE: begin
        update_tag_en[victim] = 1'b1;
        state_nxt             = FILL_RESUME;
      end
      FILL_RESUME: begin
        resume_fetch = 1'b1;
        state_nxt    = FILL_IDLE;
      end
      default: state_nxt = FILL_IDLE;
    endcase
  end

  // Miss line is captured only from IDLE; misses seen while busy are refetched.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_tag <= '0;
      line_set <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == FILL_IDLE && miss) begin
        line_tag <= miss_tag;
        line_set <= miss_set;
      end
      if (state == FILL_FILL && mem_rd_data_valid)
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (state == FILL_UPDATE)
        rr_ptr[line_set] <= (victim == ICACHE_WAY_BITS'(ICACHE_NUM_WAYS-1)) ? '0 : victim + 1'b1;
    end

  assign mem_rd_addr    = MEM_ADDR_WIDTH'({line_tag, line_set, {(ICACHE_OFF_BITS+2){1'b0}}});
  assign wr_addr        = {line_set, beat_cnt};
  assign wr_data        = mem_rd_data;
  assign update_tag_set = line_set;
  assign update_tag     = line_tag;

endmodule

// File: rtl/instruction_fetch_data.sv
// I-fetch data stage: hit resolution, per-way data read to IX, miss line fill.
// Define ICACHE_PERF_CNT_EN to add saturating perf_hits / perf_misses outputs.
module instruction_fetch_data
  import instruction_fetch_data_pkg::*;
#(
  parameter int ICACHE_LINE_WORDS = instruction_fetch_data_pkg::ICACHE_LINE_WORDS,
  parameter int MEM_ADDR_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ift_valid,
  input  ift_ifd_inf_t              ift_ifd_inf,
  input  logic                      wb_do_branch,
  input  logic                      ix_stall_if,
  output ifd_ift_inf_t              ifd_ift_inf,
  output logic                      ifd_ix_valid,
  output logic [31:0]               ifd_ix_instr,
  output logic [31:0]               ifd_ix_pc,
  output logic                      mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      mem_rd_gnt,
  input  logic                      mem_rd_data_valid,
  input  logic [31:0]               mem_rd_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]               perf_hits,
  output logic [31:0]               perf_misses
`endif
);

  localparam int AW = ICACHE_NUM_SET_BITS + ICACHE_OFF_BITS;

  ifu_address_t                         pc;
  logic [ICACHE_NUM_WAYS-1:0]           hit_way, fill_wr_en, upd_en;
  logic [ICACHE_NUM_WAYS-1:0][31:0]     way_rd_data;
  logic [AW-1:0]                        fill_wr_addr;
  logic [31:0]                          fill_wr_data, hit_instr;
  logic [ICACHE_NUM_SET_BITS-1:0]       upd_set;
  logic [ICACHE_NUM_TAG_BITS-1:0]       upd_tag;
  logic                                 hit, miss, resume, fsm_idle;

  assign pc = ift_ifd_inf.fetched_pc;

  for (genvar w = 0; w < ICACHE_NUM_WAYS; w++) begin : g_way
    assign hit_way[w] = ift_ifd_inf.valid_bits[w] && (ift_ifd_inf.tags_read[w] == pc.tag);
    bram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) u_data (
      .clk     (clk),
      .wr_en   (fill_wr_en[w]),
      .wr_addr (fill_wr_addr),
      .wr_data (fill_wr_data),
      .rd_addr ({pc.set_idx, pc.offset}),
      .rd_data (way_rd_data[w])
    );
  end

  assign hit  = ift_valid &&  (|hit_way) && !wb_do_branch;
  assign miss = ift_valid && !(|hit_way) && !wb_do_branch;

  // hit_way is one-hot on a hit, so an OR-mux is sufficient.
  always_comb begin
    hit_instr = '0;
    for (int w = 0; w < ICACHE_NUM_WAYS; w++)
      if (hit_way[w]) hit_instr = hit_instr | way_rd_data[w];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ifd_ix_valid <= 1'b0;
      ifd_ix_instr <= '0;
      ifd_ix_pc    <= '0;
    end else if (wb_do_branch) begin
      ifd_ix_valid <= 1'b0;
    end else if (!ix_stall_if) begin
      ifd_ix_valid <= hit;
      if (hit) begin
        ifd_ix_instr <= hit_instr;
        ifd_ix_pc    <= pc;
      end
    end

  instruction_fetch_data_icache_line_fill #(
    .LINE_WORDS     (ICACHE_LINE_WORDS),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_icache_line_fill (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss              (miss),
    .miss_tag          (pc.tag),
    .miss_set          (pc.set_idx),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_gnt        (mem_rd_gnt),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_rd_data       (mem_rd_data),
    .wr_en             (fill_wr_en),
    .wr_addr           (fill_wr_addr),
    .wr_data           (fill_wr_data),
    .update_tag_en     (upd_en),
    .update_tag_set    (upd_set),
    .update_tag        (upd_tag),
    .resume_fetch      (resume),
    .fsm_idle          (fsm_idle)
  );

  assign ifd_ift_inf.cache_miss           = miss;
  assign ifd_ift_inf.resume_fetch         = resume;
  assign ifd_ift_inf.cache_fetch_fsm_idle = fsm_idle;
  assign ifd_ift_inf.update_tag_en        = upd_en;
  assign ifd_ift_inf.update_tag_set       = upd_set;
  assign ifd_ift_inf.update_tag           = upd_tag;

  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n) ift_valid |-> $onehot0(hit_way));

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit && perf_hits != '1)                 perf_hits   <= perf_hits + 1'b1;
      if (miss && fsm_idle && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
    end
`endif

endmodule
